// File: rtl/vga_pkg.sv
// Shared constants and payload types for the VGA frame-buffer display path.
package vga_pkg;

    localparam int unsigned VGA_H_VIS  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;
    localparam int unsigned VGA_V_VIS  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;

    localparam int unsigned H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned FB_AW = 19;
    localparam int unsigned PIX_W = 12;
    localparam int unsigned CH_W  = 4;

    // RGB444 field positions within a frame-buffer word
    localparam int unsigned R_LSB = 8;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus h/v raster counters; sync/visible flags describe the
// position that the counters hold, and are refreshed together with them.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_H_VIS,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_VIS  = VGA_V_VIS,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_step_c,
    output logic o_cap_slot_c,
    output logic o_frame_wrap_c,
    output logic o_visible_nxt_c,
    output logic o_visible,
    output logic o_hs,
    output logic o_vs,
    output logic o_vblank_start
);

    localparam int unsigned LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW          = $clog2(LINE_LEN);
    localparam int unsigned VW          = $clog2(FRAME_LINES);

    logic [1:0]    r_ph;
    logic [HW-1:0] r_h;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] r_v;
    logic [VW-1:0] w_v_nxt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_hs_nxt;
    logic          w_vs_nxt;
    logic          w_vblank_nxt;

    // Next raster position and the flags that will describe it
    always_comb begin
        w_h_wrap        = (r_h == HW'(LINE_LEN - 1));
        w_v_wrap        = (r_v == VW'(FRAME_LINES - 1));
        w_h_nxt         = w_h_wrap ? '0 : r_h + HW'(1);
        w_v_nxt         = r_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v + VW'(1);
        end
        o_pix_step_c    = (r_ph == 2'd3);
        o_cap_slot_c    = (r_ph == 2'd1);
        o_frame_wrap_c  = o_pix_step_c && w_h_wrap && w_v_wrap;
        o_visible_nxt_c = (w_h_nxt < HW'(H_VIS)) && (w_v_nxt < VW'(V_VIS));
        w_hs_nxt        = (w_h_nxt >= HW'(H_VIS + H_FP)) &&
                          (w_h_nxt <  HW'(H_VIS + H_FP + H_SYNC));
        w_vs_nxt        = (w_v_nxt >= VW'(V_VIS + V_FP)) &&
                          (w_v_nxt <  VW'(V_VIS + V_FP + V_SYNC));
        w_vblank_nxt    = (w_h_nxt == '0) && (w_v_nxt == VW'(V_VIS));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ph           <= '0;
            r_h            <= '0;
            r_v            <= '0;
            o_visible      <= 1'b1;
            o_hs           <= 1'b0;
            o_vs           <= 1'b0;
            o_vblank_start <= 1'b0;
        end else begin
            r_ph <= r_ph + 2'd1;
            if (o_pix_step_c) begin
                r_h            <= w_h_nxt;
                r_v            <= w_v_nxt;
                o_visible      <= o_visible_nxt_c;
                o_hs           <= w_hs_nxt;
                o_vs           <= w_vs_nxt;
                o_vblank_start <= w_vblank_nxt;
            end
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the RGB444 frame buffer through BRAM port B and drives VGA colour/sync
// with all outputs two cycles behind addrB, plus a once-per-frame vblank tick.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_H_VIS,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_VIS  = VGA_V_VIS,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP
) (
    input  logic             Clk_100M,
    input  logic             Rst_n,
    output logic [FB_AW-1:0] addrB,
    input  logic [PIX_W-1:0] doutB,
    output logic [CH_W-1:0]  vga_r,
    output logic [CH_W-1:0]  vga_g,
    output logic [CH_W-1:0]  vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             frame_tick
);

    logic             w_pix_step;
    logic             w_cap_slot;
    logic             w_frame_wrap;
    logic             w_visible_nxt;
    logic             w_visible;
    logic             w_hs;
    logic             w_vs;
    logic             w_vblank_start;
    logic [FB_AW-1:0] r_index;
    logic [FB_AW-1:0] w_index_nxt;
    logic             r_vis1;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_tick1;
    rgb444_t          w_pix;

    vga_timing_gen #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .i_clk           (Clk_100M),
        .i_rst_n         (Rst_n),
        .o_pix_step_c    (w_pix_step),
        .o_cap_slot_c    (w_cap_slot),
        .o_frame_wrap_c  (w_frame_wrap),
        .o_visible_nxt_c (w_visible_nxt),
        .o_visible       (w_visible),
        .o_hs            (w_hs),
        .o_vs            (w_vs),
        .o_vblank_start  (w_vblank_start)
    );

    assign w_pix = rgb444_t'(doutB);

    // r_index counts visible pixels already passed, so it is the index of the next one
    always_comb begin
        w_index_nxt = r_index;
        if (w_frame_wrap) begin
            w_index_nxt = '0;
        end else if (w_visible) begin
            w_index_nxt = r_index + FB_AW'(1);
        end
    end

    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_index <= '0;
            addrB   <= '0;
        end else if (w_pix_step) begin
            r_index <= w_index_nxt;
            addrB   <= w_visible_nxt ? w_index_nxt : '0;
        end
    end

    // Flags wait one cycle alongside the BRAM read
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_vis1  <= 1'b0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_tick1 <= 1'b0;
        end else begin
            r_vis1  <= w_visible;
            r_hs1   <= w_hs;
            r_vs1   <= w_vs;
            r_tick1 <= w_vblank_start;
        end
    end

    // Output stage samples doutB only in the slot two cycles after addrB changes
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_cap_slot && r_tick1;
            if (w_cap_slot) begin
                vga_r  <= r_vis1 ? w_pix.r : '0;
                vga_g  <= r_vis1 ? w_pix.g : '0;
                vga_b  <= r_vis1 ? w_pix.b : '0;
                vga_hs <= ~r_hs1;
                vga_vs <= ~r_vs1;
            end
        end
    end

endmodule
